// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: one CHUNK-bit slice per stage, slice carry registered
// between stages, valid/ready on both sides with a whole-pipe stall.
module adder_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             sub_i,
    input  logic             carry_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o
);

    localparam int unsigned SAFE_CHUNK = (CHUNK >= 1) ? CHUNK : 1;
    localparam int unsigned STAGES     = (WIDTH / SAFE_CHUNK >= 1) ? WIDTH / SAFE_CHUNK : 1;
    localparam int unsigned LAST       = STAGES - 1;

    if (CHUNK < 1 || (WIDTH % SAFE_CHUNK) != 0) begin : g_param_check
        $fatal(1, "adder_pipe: WIDTH must be a nonzero multiple of CHUNK");
    end

    function automatic logic [CHUNK:0] add_slice(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    logic             v_q   [STAGES];
    logic             v_d   [STAGES];
    logic             c_q   [STAGES];
    logic             c_d   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] r_q   [STAGES];
    logic [WIDTH-1:0] r_d   [STAGES];
    logic [CHUNK:0]   slice_sum [STAGES];
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic             en;

    assign en      = ready_i | ~v_q[LAST];
    assign ready_o = en;
    assign b_eff   = sub_i ? ~b_i : b_i;
    assign cin     = sub_i | carry_i;

    always_comb begin
        slice_sum[0]             = add_slice(a_i[CHUNK-1:0], b_eff[CHUNK-1:0], cin);
        v_d[0]                   = valid_i;
        a_d[0]                   = a_i;
        b_d[0]                   = b_eff;
        r_d[0]                   = '0;
        r_d[0][CHUNK-1:0]        = slice_sum[0][CHUNK-1:0];
        c_d[0]                   = slice_sum[0][CHUNK];
        for (int k = 1; k < STAGES; k++) begin
            slice_sum[k] = add_slice(a_q[k-1][k*CHUNK +: CHUNK], b_q[k-1][k*CHUNK +: CHUNK],
                                     c_q[k-1]);
            v_d[k]                   = v_q[k-1];
            a_d[k]                   = a_q[k-1];
            b_d[k]                   = b_q[k-1];
            r_d[k]                   = r_q[k-1];
            r_d[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
            c_d[k]                   = slice_sum[k][CHUNK];
        end
    end

    // Only the valid bits need reset; the outputs are gated by the final valid bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                r_q[k] <= r_d[k];
                c_q[k] <= c_d[k];
            end
        end
    end

    assign valid_o    = v_q[LAST];
    assign res_o      = valid_o ? r_q[LAST] : '0;
    assign carry_o    = valid_o & c_q[LAST];
    assign overflow_o = valid_o & (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                                & (r_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
    assign zero_o     = ~|res_o;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: expected results queued at acceptance, compared on
// consumption, with latency, stall-hold and reset checks.
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        sub_i = 1'b0;
    logic        carry_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] res_o;
    logic        carry_o;
    logic        overflow_o;
    logic        zero_o;

    always #5 clk = ~clk;

    adder_pipe #(
        .WIDTH(32),
        .CHUNK(8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .sub_i     (sub_i),
        .carry_i   (carry_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .res_o     (res_o),
        .carry_o   (carry_o),
        .overflow_o(overflow_o),
        .zero_o    (zero_o)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        carry;
        logic        ovf;
        int unsigned acc;
        logic        lat;
    } item_t;

    item_t       sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    logic        lat_on = 1'b1;
    logic [31:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic item_t model(input logic s, input logic c,
                                    input logic [31:0] a, input logic [31:0] b);
        item_t       e;
        logic [31:0] be;
        logic [32:0] full;
        be      = s ? ~b : b;
        full    = {1'b0, a} + {1'b0, be} + {32'd0, (s | c)};
        e       = '0;
        e.res   = full[31:0];
        e.carry = full[32];
        e.ovf   = (a[31] == be[31]) && (full[31] != a[31]);
        return e;
    endfunction

    // One clock: drive at the falling edge, settle, check outputs, then log acceptance.
    task automatic step(input logic v, input logic s, input logic c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic r, input logic rst);
        item_t e;
        @(negedge clk);
        valid_i = v; sub_i = s; carry_i = c; a_i = a; b_i = b; ready_i = r; rst_i = rst;
        #1;
        cyc++;
        if (rst) begin
            sb.delete();
            return;
        end
        chk("ready_o", {63'd0, ready_o}, {63'd0, r | ~valid_o});
        if (valid_o && r) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid_o", {63'd0, valid_o}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("result", {29'd0, res_o, carry_o, overflow_o, zero_o},
                    {29'd0, e.res, e.carry, e.ovf, (e.res == 32'd0)});
                if (e.lat) chk("latency", {32'd0, cyc - e.acc}, 64'd4);
            end
        end
        if (v && (r || !valid_o)) begin
            e     = model(s, c, a, b);
            e.acc = cyc;
            e.lat = lat_on;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input logic r);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, r, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1'b1);
        chk("drain_empty", {32'd0, sb.size()}, 64'd0);
    endtask

    task automatic chk_reset_outs();
        chk("reset_outputs", {26'd0, valid_o, res_o, carry_o, overflow_o, zero_o, ready_o},
            {26'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk_reset_outs();
        end

        // Plain add and full carry chain
        step(1'b1, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0);
        drain();
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        drain();

        // Subtract; carry_i must be ignored in the last one
        step(1'b1, 1'b1, 1'b0, 32'd5, 32'd7, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'd9, 32'd3, 1'b1, 1'b0);
        drain();

        // Back-to-back stream: fixed latency implies consecutive, in-order results
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, i, 32'd1, 1'b1, 1'b0);
        drain();

        // Backpressure: 3-cycle stall while results are pending
        lat_on = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h100 * i, 32'h11, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'hDEAD_0000, 32'h1, 1'b0, 1'b0);
        held = res_o;
        chk("stall_valid", {63'd0, valid_o}, 64'd1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'hDEAD_0000, 32'h1, 1'b0, 1'b0);
            chk("stall_hold_res", {32'd0, res_o}, {32'd0, held});
            chk("stall_valid", {63'd0, valid_o}, 64'd1);
        end
        drain();
        lat_on = 1'b1;

        // Reset mid-flight discards everything in the pipe
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd10 + i, 32'd1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            chk_reset_outs();
        end
        step(1'b1, 1'b0, 1'b0, 32'h1234, 32'h1111, 1'b1, 1'b0);
        drain();

        chk("scoreboard_empty", {32'd0, sb.size()}, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
